// File: rtl/pwm_dac.sv
// PWM output stage: latches one attenuated 8-bit sample per 255-clock period
// and drives a registered single-bit PWM signal for the RC-filtered output.
module pwm_dac (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] wave,
    input  logic [1:0] amp,
    input  logic       mute,
    output logic       pwm,
    output logic       sample_req
);

    localparam logic [7:0] LAST_CNT = 8'd254;
    localparam logic [7:0] MIDSCALE = 8'd128;

    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic              boundary;
    logic signed [8:0] diff_s;
    logic signed [8:0] shift_s;
    logic [7:0]        scaled;

    // Attenuate about midscale; the shifted offset always fits back into 0..255.
    assign diff_s  = $signed({1'b0, wave}) - 9'sd128;
    assign shift_s = diff_s >>> amp;
    assign scaled  = shift_s[7:0] + MIDSCALE;

    assign boundary = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        pwm_d  = 1'b0;
        if (en) begin
            pwm_d = (cnt_q < duty_q);
            if (boundary) begin
                cnt_d  = 8'd0;
                duty_d = mute ? MIDSCALE : scaled;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 8'd0;
            duty_q <= MIDSCALE;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    // sample_req has no ready: wave/amp/mute are taken on the same enabled edge it is high.
    assign pwm        = pwm_q;
    assign sample_req = en & boundary;

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Output stage of the function generator: consumes the 8-bit unsigned sample stream produced by the waveform generators (sine, half-wave, square, triangle) and converts it to a single-bit PWM signal for the board's RC-filtered analog output. A new sample is latched once per PWM period and attenuated about midscale (128). The block emits a one-cycle sample request at each period boundary, which upstream stages can use as a clock enable.

## Interface
Parameters: none; the period (255 clocks) and the sample width (8) are fixed.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run enable; when low, the block pauses
- wave  input  8  unsigned sample, midscale 128; sampled only at period boundaries
- amp  input  2  attenuation shift (0 = full scale, 3 = 1/8); sampled together with wave
- mute  input  1  when high at a boundary, the loaded duty is 128
- pwm  output  1  registered PWM output
- sample_req  output  1  high during the last cycle of each period (decoded from the counter)

## Operation
- State: 8-bit period counter cnt (0..254), 8-bit duty register duty, 1-bit pwm register.
- Reset (asynchronous, takes effect immediately):
  - cnt = 0, duty = 128, pwm = 0.
  - sample_req = 0.
- On each rising edge with en = 1:
  - cnt advances to cnt+1, or wraps to 0 when cnt = 254. The period is exactly 255 clocks.
  - If cnt = 254 before the edge, duty loads scaled(wave, amp), or 128 if mute = 1.
  - pwm <= (cnt < duty), using the values of cnt and duty before the edge.
- On each rising edge with en = 0:
  - cnt and duty hold.
  - pwm <= 0.
- sample_req = en AND (cnt == 254).
- Scaling arithmetic:
  - d = wave − 128, as a 9-bit signed value (range −128..127).
  - s = d >>> amp (arithmetic shift, rounds toward −inf).
  - scaled = s + 128, truncated to 8 bits. The result is always in 0..255, so no saturation is needed.
- Duty extremes:
  - duty = 0: pwm stays low for the whole period.
  - duty = 255: pwm stays high for all 255 cycles (cnt never reaches 255).
- Changes to wave, amp or mute between boundaries have no effect.
- Simultaneous events:
  - en falling in the cycle where cnt = 254: no load occurs, and sample_req is 0 in that cycle. The load happens at the first enabled edge with cnt = 254.
  - rst asserted at any point: all state returns to reset values immediately, and the sample in flight is discarded.

## Timing
- Latency: wave is captured at boundary edge E. The new duty appears on pwm starting at edge E+1.
- pwm trails cnt by one cycle. In steady state, pwm is high for exactly duty consecutive cycles out of every 255.
- The first period after reset runs at duty 128: pwm is high for 128 cycles, beginning one edge after en is first seen high.
- sample_req pulses are exactly 255 enabled clocks apart. Disabled cycles stretch the spacing one-for-one.
- A pause (en = 0 for N cycles) lengthens the current period by N cycles. pwm is forced low for those N cycles, plus the one-cycle register lag.

## Test plan
- Reset: hold rst with en=1, wave=200 → pwm=0 and sample_req=0 throughout reset. After release, the first period shows 128 pwm-high cycles, then sample_req fires once.
- Steady state: wave=200, amp=0, mute=0 → every following period has exactly 200 high cycles out of 255, and sample_req pulses every 255 clocks.
- Scaling:
  - wave=0, amp=1 → duty 64.
  - wave=255, amp=3 → duty 143.
  - wave=0, amp=3 → duty 112.
  - mute=1 with any wave → duty 128.
- Extremes: wave=0, amp=0 → pwm never high. wave=255, amp=0 → pwm high for all 255 cycles with no low gap.
- Mid-period change: switch wave from 50 to 220 when cnt=100 → the current period completes with 50 high cycles, and the next period has 220.
- Pause and reset mid-run:
  - Drop en for 10 cycles at cnt=30 → pwm low during the pause, period length becomes 265, no extra sample_req.
  - Assert rst at cnt=77 → immediate return to cnt=0, duty=128, pwm=0.
